// File: rtl/mips_uc_pkg.sv
// -----------------------------------------------------------------------------
// mips_uc_pkg
// Shared definitions for the data-memory arbiter: arbiter FSM state encoding,
// master index constants and the beat-counter geometry.
// -----------------------------------------------------------------------------
package mips_uc_pkg;

    // Arbiter ownership state: nobody owns the port, or master 0/1 holds it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Master indices on the request/grant vectors.
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    // Beat counter width and its saturation value.
    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : mips_uc_pkg

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin choice. With one requester it picks that
// one; with both it picks the master not named by i_last_grant.
// Ports:
//   i_req[1:0]     request vector (bit n = master n)
//   i_last_grant   index of the master that most recently released the port
//   o_pick[1:0]    one-hot choice, 00 when nobody requests
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_pick
);

    always_comb begin
        // NOTE: a default is assigned before the case so no path can infer a latch.
        o_pick = 2'b00;
        case (i_req)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = i_last_grant ? 2'b01 : 2'b10;
            default: o_pick = 2'b00;
        endcase
    end

endmodule : rr_pick2

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Arbitrates one data-memory port between the CPU bridge (master 0) and the
// DMA engine (master 1). A grant from IDLE is itself the first beat; a master
// that keeps m_lock high stays owner for further beats, up to MAX_BURST beats
// when the other master is waiting. Read beats return m_rvalid one cycle
// later together with the registered memory read data.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   m_req, m_lock          per-master request / keep-grant
//   m0_*/m1_*              per-master byte address, byte enables, write data
//   m_gnt                  one-hot grant (combinational)
//   m_rvalid, m_rdata      read return (registered)
//   mem_ce/addr/wbe/wdata  memory request side; mem_rdata memory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import mips_uc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_req,
    input  logic [1:0]            m_lock,
    input  logic [31:0]           m0_addr,
    input  logic [31:0]           m1_addr,
    input  logic [3:0]            m0_wbe,
    input  logic [3:0]            m1_wbe,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [1:0]            m_gnt,
    output logic [1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  mem_ce,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wbe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Counter value after the last beat a waiting master may be made to wait for.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t            r_state, w_state_next;
    logic                  r_last_grant, w_last_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [1:0]            w_pick;
    logic [1:0]            w_gnt;
    logic                  w_owner;
    logic                  w_beat;
    logic                  w_other_req;
    logic                  w_read;
    logic                  w_unused_addr;

    rr_pick2 u_pick (
        .i_req        (m_req),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick)
    );

    // Grant decode: IDLE grants the round-robin pick, an owner sees only its own request.
    always_comb begin
        w_gnt   = 2'b00;
        w_owner = MST_CPU;
        case (r_state)
            ST_IDLE: begin
                w_gnt   = w_pick;
                w_owner = w_pick[1] ? MST_DMA : MST_CPU;
            end
            ST_OWN0: begin
                w_gnt   = {1'b0, m_req[0]};
                w_owner = MST_CPU;
            end
            ST_OWN1: begin
                w_gnt   = {m_req[1], 1'b0};
                w_owner = MST_DMA;
            end
            default: ;
        endcase
        // Nothing may be granted while reset is held, even though IDLE would pick.
        if (!rst) w_gnt = 2'b00;
    end

    assign w_beat      = |w_gnt;
    assign w_other_req = (w_owner == MST_DMA) ? m_req[0] : m_req[1];

    // Ownership bookkeeping on each cycle.
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last_grant;
        w_cnt_next   = r_cnt;
        if (w_beat) begin
            // The granting beat from IDLE restarts the count; owner beats saturate.
            if (r_state == ST_IDLE)    w_cnt_next = '0;
            else if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + 1'b1;

            if (m_lock[w_owner] && !(w_other_req && (w_cnt_next >= BURST_LAST))) begin
                w_state_next = (w_owner == MST_DMA) ? ST_OWN1 : ST_OWN0;
            end else begin
                w_state_next = ST_IDLE;
                w_last_next  = w_owner;
            end
        end else if (r_state != ST_IDLE) begin
            // Owner dropped its request: release without a beat.
            w_state_next = ST_IDLE;
            w_last_next  = w_owner;
        end
    end

    // Memory side follows the granted master.
    assign mem_ce    = w_beat;
    assign mem_addr  = (w_owner == MST_DMA) ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
    assign mem_wbe   = (w_owner == MST_DMA) ? m1_wbe : m0_wbe;
    assign mem_wdata = (w_owner == MST_DMA) ? m1_wdata : m0_wdata;
    assign w_read    = (mem_wbe == 4'b0000);

    // Byte-lane and out-of-range address bits are deliberately dropped.
    assign w_unused_addr = ^{m0_addr, m1_addr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rvalid     <= 2'b00;
            r_rdata      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_next;
            r_last_grant <= w_last_next;
            r_cnt        <= w_cnt_next;
            r_rvalid     <= w_gnt & {2{w_read}};
            r_rdata      <= mem_rdata;
        end
    end

    assign m_gnt    = w_gnt;
    assign m_rvalid = r_rvalid;
    assign m_rdata  = r_rdata;

endmodule : data_mem_arbiter

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 30: word-address width toward memory.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked beats per grant (range 1..255).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 m_req[1:0]  input  2  per-master request (index 0 = CPU bridge, index 1 = DMA).
REQ-008 m_lock[1:0]  input  2  per-master request to keep the grant for the next beat.
REQ-009 m0_addr, m1_addr  input  32 each  byte address; bits [ADDR_WIDTH+1:2] are forwarded.
REQ-010 m0_wbe, m1_wbe  input  4 each  byte write enables; all-zero = read.
REQ-011 m0_wdata, m1_wdata  input  DATA_WIDTH each  write data.
REQ-012 m_gnt[1:0]  output  2  one-hot grant; a beat completes on any cycle where req and gnt are both high.
REQ-013 m_rvalid[1:0]  output  2  read data valid for that master.
REQ-014 m_rdata  output  DATA_WIDTH  registered copy of mem_rdata, shared by both masters.
REQ-015 mem_ce  output  1  memory access strobe.
REQ-016 mem_addr  output  ADDR_WIDTH  memory word address.
REQ-017 mem_wbe  output  4  memory byte enables.
REQ-018 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-019 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_ce.

Function
REQ-020 FSM states: IDLE, OWN0, OWN1. m_gnt is decoded combinationally from the state and m_req; the state register updates on clk.
REQ-021 IDLE, no requests: m_gnt=00, mem_ce=0, and the state remains IDLE.
REQ-022 IDLE, one request: grant that master in the same cycle and enter OWNn.
REQ-023 IDLE, both requesting: grant the master not named by the 1-bit last_grant pointer; last_grant resets to 1, so M0 wins first.
REQ-024 OWNn: m_gnt[n]=m_req[n], mem_ce=m_req[n], and mem_addr, mem_wbe and mem_wdata are muxed from master n; otherwise mem_ce=0.
REQ-025 Beat counter is 8 bits; it clears on each new grant and increments on each completed beat in OWNn.
REQ-026 Leave OWNn to IDLE when a beat completes with m_lock[n]=0.
REQ-027 Leave OWNn to IDLE when m_req[n] drops.
REQ-028 Leave OWNn to IDLE when the counter reaches MAX_BURST-1 and the other master is requesting (forced release).
REQ-029 With no other requester, a locked master keeps the grant past MAX_BURST and the counter saturates.
REQ-030 On leaving OWNn, last_grant becomes n.
REQ-031 At most one m_gnt bit is high in any cycle.
REQ-032 The memory is never accessed with mem_ce=1 while m_gnt=00.
REQ-033 Read beat (wbe=0): m_rvalid[n] pulses exactly one cycle later, and m_rdata holds mem_rdata captured on that edge.
REQ-034 Write beat: no rvalid pulse.
REQ-035 Back-to-back reads by alternating masters give rvalid strictly in grant order, one per cycle, with no lost beats.
REQ-036 Address bits above ADDR_WIDTH+1 and bits [1:0] are ignored; no range check is performed.

Reset
REQ-037 Asserting rst asynchronously forces: state=IDLE, last_grant=1, counter=0, m_rvalid=00, m_rdata=0.
REQ-038 While rst is low: m_gnt=00 and mem_ce=0.
REQ-039 Reset during a beat aborts it; no rvalid pulse follows deassertion.
REQ-040 The first grant is possible on the first rising edge after rst deasserts.

Structure
REQ-041 The FSM state encoding and the master index constants (CPU=0, DMA=1) SHALL live in the shared mips_uc_pkg package.
REQ-042 A single sub-module rr_pick2 SHALL be used: a combinational two-way round-robin choice taking m_req and last_grant.
REQ-043 No other sub-modules; target size is 120-250 lines of RTL.

Verification
REQ-044 Reset: hold rst=0 with m_req=11 -> m_gnt=00, mem_ce=0; release -> first cycle m_gnt=01.
REQ-045 Contention: m_req=11, m_lock=00, all reads -> grants alternate 01,10,01,10 on successive beats, with rvalid following each grant by one cycle.
REQ-046 Burst cap: MAX_BURST=4, M1 locked, M0 requests from the second beat -> M1 gets exactly 4 beats, then M0 is granted.
REQ-047 Uncontended lock: M0 locked for 20 beats, M1 idle -> continuous grant for all 20, counter held at 255 max, no gaps.
REQ-048 Write pass-through: M1 writes 0xDEADBEEF to byte address 0x00000010 with wbe=1111 -> mem_addr=0x4, mem_wbe=1111, mem_wdata=0xDEADBEEF, no rvalid.
REQ-049 Mid-read reset: M0 read granted, rst pulsed low for half a cycle -> m_rvalid stays 00 and state returns to IDLE.
